nand_dq_capture: RTL and testbench

Read-side companion to the NAND strobe toggle generator. It watches the RE# strobe that the generator drives and samples the 8-bit DQ bus on each RE# rising edge. It counts the captured bytes up to a programmed total and buffers them in a small FIFO for the downstream consumer, which pulls data with a valid/ready handshake. It sits between the NAND pad registers and the controller's read datapath, in the same `clk` domain as the toggle generator.

---
 rtl/nand_pkg.sv | 15 +
 rtl/nand_sync_fifo.sv | 74 +++++++
 rtl/nand_dq_capture.sv | 151 +++++++++++++++
 tb/tb_nand_dq_capture.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_pkg.sv
// Shared definitions for the NAND read-capture path: data/count widths and
// the capture state encoding.
package nand_pkg;

    localparam int NAND_DATA_W = 8;
    localparam int NAND_CNT_W  = 12;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_CAPTURE = 2'd1,
        CAP_DRAIN   = 2'd2,
        CAP_DONE    = 2'd3
    } cap_state_e;

endpackage

// File: rtl/nand_sync_fifo.sv
// Small synchronous FIFO buffering captured DQ bytes. Pointers carry an extra
// wrap bit so full and empty can be told apart. A push is accepted when full
// only if a pop happens in the same cycle. There is no bypass path: a pushed
// byte becomes visible on the cycle after the push. Flush empties the FIFO
// and discards any push or pop in the same cycle.
module nand_sync_fifo
    import nand_pkg::*;
#(
    parameter int WIDTH = NAND_DATA_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer and memory contents from push, pop and flush requests.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = wr_data;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Pointer and storage registers; storage clears on reset so rd_data reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/nand_dq_capture.sv
// Read-side capture for NAND bursts: samples DQ on each RE# rising edge,
// counts bytes up to a latched total and buffers them for a valid/ready
// consumer. The input registers, edge detect and burst FSM live here. Byte
// storage is in nand_sync_fifo.
module nand_dq_capture
    import nand_pkg::*;
#(
    parameter int DATA_W     = NAND_DATA_W,
    parameter int CNT_W      = NAND_CNT_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  cnt_upto,
    input  logic              re_n,
    input  logic [DATA_W-1:0] dq,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  byte_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    cap_state_e        state_q, state_d;
    logic              re_r_q, re_p_q;
    logic [DATA_W-1:0] dq_r_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              rise;
    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_full, fifo_empty;

    assign rise     = re_r_q & ~re_p_q;
    assign rd_valid = !fifo_empty;
    assign fifo_pop = rd_valid && rd_ready;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign byte_cnt = byte_cnt_q;

    // Pad-side input registers; RE# history resets high so reset exit is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            re_r_q <= 1'b1;
            re_p_q <= 1'b1;
            dq_r_q <= '0;
        end else begin
            re_r_q <= re_n;
            re_p_q <= re_r_q;
            dq_r_q <= dq;
        end
    end

    // Burst sequencing: start, capture, drain, complete, and abort on enable low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                done_d = 1'b0;
                if (enable) begin
                    cnt_d      = cnt_upto;
                    byte_cnt_d = '0;
                    overflow_d = 1'b0;
                    fifo_flush = 1'b1;
                    state_d    = (cnt_upto == '0) ? CAP_DRAIN : CAP_CAPTURE;
                end
            end
            CAP_CAPTURE: begin
                if (!enable) begin
                    fifo_flush = 1'b1;
                    done_d     = 1'b0;
                    state_d    = CAP_IDLE;
                end else if (rise) begin
                    fifo_push  = 1'b1;
                    byte_cnt_d = byte_cnt_q + CNT_ONE;
                    if (byte_cnt_q + CNT_ONE == cnt_q) begin
                        state_d = CAP_DRAIN;
                    end
                end
            end
            CAP_DRAIN: begin
                if (!enable) begin
                    fifo_flush = 1'b1;
                    done_d     = 1'b0;
                    state_d    = CAP_IDLE;
                end else if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = CAP_DONE;
                end
            end
            CAP_DONE: begin
                done_d = 1'b1;
                if (!enable) begin
                    done_d  = 1'b0;
                    state_d = CAP_IDLE;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = CAP_IDLE;
            end
        endcase
        if (fifo_push && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CAP_IDLE;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    nand_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .wr_data (dq_r_q),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_nand_dq_capture.sv
// Directed bench for nand_dq_capture: nominal burst, overflow under
// backpressure, push+pop while full, abort, zero-length burst and reset
// mid-capture. Popped bytes are collected by a monitor and compared to
// hand-computed sequences.
module tb_nand_dq_capture;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 12;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [CNT_W-1:0]  cnt_upto;
    logic              re_n;
    logic [DATA_W-1:0] dq;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              done;
    logic              overflow;
    logic [CNT_W-1:0]  byte_cnt;

    logic [DATA_W-1:0] pop_q [$];
    int num_checks = 0;
    int num_passed = 0;

    nand_dq_capture #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .cnt_upto (cnt_upto),
        .re_n     (re_n),
        .dq       (dq),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .done     (done),
        .overflow (overflow),
        .byte_cnt (byte_cnt)
    );

    always #5 clk = ~clk;

    // Record every byte that will be popped at the coming rising edge.
    always @(negedge clk) begin
        if (!reset && rd_valid && rd_ready) begin
            pop_q.push_back(rd_data);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed === expected) begin
            num_passed++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One RE# pulse: one cycle low, then one cycle high carrying byte b.
    task automatic applyStimulus(input logic [DATA_W-1:0] b);
        re_n = 1'b0;
        tick();
        re_n = 1'b1;
        dq   = b;
        tick();
    endtask

    task automatic waitDone(input string tag, input int max_cycles);
        int n = 0;
        while (!done && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        cnt_upto = '0;
        re_n     = 1'b1;
        dq       = '0;
        rd_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_byte_cnt", 32'(byte_cnt), 32'd0);

        // Nominal burst of four bytes with the consumer always ready.
        cnt_upto = 12'd4;
        rd_ready = 1'b1;
        enable   = 1'b1;
        tick();
        pop_q.delete();
        applyStimulus(8'h11);
        checkOutput("nom_latency_pre", 32'(rd_valid), 32'd0);
        tick();
        checkOutput("nom_latency_valid", 32'(rd_valid), 32'd1);
        checkOutput("nom_latency_data", 32'(rd_data), 32'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        waitDone("nom_done", 20);
        checkOutput("nom_pop_count", 32'(pop_q.size()), 32'd4);
        if (pop_q.size() == 4) begin
            checkOutput("nom_pop0", 32'(pop_q[0]), 32'h11);
            checkOutput("nom_pop1", 32'(pop_q[1]), 32'h22);
            checkOutput("nom_pop2", 32'(pop_q[2]), 32'h33);
            checkOutput("nom_pop3", 32'(pop_q[3]), 32'h44);
        end
        checkOutput("nom_byte_cnt", 32'(byte_cnt), 32'd4);
        checkOutput("nom_overflow", 32'(overflow), 32'd0);
        enable = 1'b0;
        tick();
        checkOutput("nom_done_clear", 32'(done), 32'd0);

        // Ten bytes into an eight-entry FIFO with no consumer.
        rd_ready = 1'b0;
        cnt_upto = 12'd10;
        enable   = 1'b1;
        tick();
        pop_q.delete();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(8'(i));
        end
        repeat (3) tick();
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_byte_cnt", 32'(byte_cnt), 32'd10);
        checkOutput("ovf_done_early", 32'(done), 32'd0);
        checkOutput("ovf_head", 32'(rd_data), 32'h01);
        rd_ready = 1'b1;
        waitDone("ovf_done", 30);
        checkOutput("ovf_pop_count", 32'(pop_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < pop_q.size(); i++) begin
            checkOutput($sformatf("ovf_pop%0d", i), 32'(pop_q[i]), 32'(i + 1));
        end
        enable = 1'b0;
        tick();
        rd_ready = 1'b0;

        // Full FIFO receiving a ninth byte on the same edge as a pop.
        cnt_upto = 12'd9;
        enable   = 1'b1;
        tick();
        pop_q.delete();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(8'(8'h20 + i));
        end
        repeat (2) tick();
        checkOutput("full_byte_cnt8", 32'(byte_cnt), 32'd8);
        applyStimulus(8'h29);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        tick();
        checkOutput("full_overflow", 32'(overflow), 32'd0);
        checkOutput("full_byte_cnt9", 32'(byte_cnt), 32'd9);
        rd_ready = 1'b1;
        waitDone("full_done", 30);
        checkOutput("full_pop_count", 32'(pop_q.size()), 32'd9);
        if (pop_q.size() == 9) begin
            checkOutput("full_pop_first", 32'(pop_q[0]), 32'h21);
            checkOutput("full_pop_mid", 32'(pop_q[4]), 32'h25);
            checkOutput("full_pop_last", 32'(pop_q[8]), 32'h29);
        end
        enable = 1'b0;
        tick();
        rd_ready = 1'b0;

        // Abort after two of six bytes.
        cnt_upto = 12'd6;
        enable   = 1'b1;
        tick();
        applyStimulus(8'h51);
        applyStimulus(8'h52);
        tick();
        checkOutput("abort_pre_valid", 32'(rd_valid), 32'd1);
        checkOutput("abort_pre_cnt", 32'(byte_cnt), 32'd2);
        enable = 1'b0;
        tick();
        checkOutput("abort_valid", 32'(rd_valid), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_cnt_hold", 32'(byte_cnt), 32'd2);
        applyStimulus(8'h53);
        applyStimulus(8'h54);
        tick();
        checkOutput("abort_ignore_cnt", 32'(byte_cnt), 32'd2);
        checkOutput("abort_ignore_valid", 32'(rd_valid), 32'd0);

        // Zero-length burst completes without pushes.
        cnt_upto = 12'd0;
        enable   = 1'b1;
        tick();
        checkOutput("zero_done_early", 32'(done), 32'd0);
        tick();
        checkOutput("zero_done", 32'(done), 32'd1);
        applyStimulus(8'h77);
        applyStimulus(8'h78);
        tick();
        checkOutput("zero_valid", 32'(rd_valid), 32'd0);
        checkOutput("zero_byte_cnt", 32'(byte_cnt), 32'd0);
        checkOutput("zero_done_hold", 32'(done), 32'd1);
        enable = 1'b0;
        tick();

        // Reset asserted in the middle of a capture.
        cnt_upto = 12'd4;
        enable   = 1'b1;
        tick();
        applyStimulus(8'h61);
        applyStimulus(8'h62);
        tick();
        checkOutput("mid_pre_valid", 32'(rd_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("mid_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("mid_rd_data", 32'(rd_data), 32'd0);
        checkOutput("mid_done", 32'(done), 32'd0);
        checkOutput("mid_overflow", 32'(overflow), 32'd0);
        checkOutput("mid_byte_cnt", 32'(byte_cnt), 32'd0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Clean burst after reset.
        cnt_upto = 12'd2;
        rd_ready = 1'b1;
        enable   = 1'b1;
        tick();
        pop_q.delete();
        applyStimulus(8'hA5);
        applyStimulus(8'h5A);
        waitDone("post_done", 20);
        checkOutput("post_pop_count", 32'(pop_q.size()), 32'd2);
        if (pop_q.size() == 2) begin
            checkOutput("post_pop0", 32'(pop_q[0]), 32'hA5);
            checkOutput("post_pop1", 32'(pop_q[1]), 32'h5A);
        end
        checkOutput("post_byte_cnt", 32'(byte_cnt), 32'd2);
        enable = 1'b0;
        tick();

        $display("%0d/%0d checks passed", num_passed, num_checks);
        $finish;
    end

endmodule
